// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer-facing bundle of sync_fifo_ctrl. The controller takes the slave modport.
// When SYNC_FIFO_ERR_FLAGS_EN is defined, the bundle also carries the sticky overflow/underflow flags.
interface sync_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
);
    logic                  wr_en_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  rd_en_i;
    logic                  flush_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_valid_o;
    logic                  full_o;
    logic                  empty_o;
    logic [ADDR_WIDTH:0]   count_o;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic                  overflow_o;
    logic                  underflow_o;

    modport master (
        output wr_en_i, wr_data_i, rd_en_i, flush_i,
        input  rd_data_o, rd_valid_o, full_o, empty_o, count_o,
        input  overflow_o, underflow_o
    );

    modport slave (
        input  wr_en_i, wr_data_i, rd_en_i, flush_i,
        output rd_data_o, rd_valid_o, full_o, empty_o, count_o,
        output overflow_o, underflow_o
    );
`else
    modport master (
        output wr_en_i, wr_data_i, rd_en_i, flush_i,
        input  rd_data_o, rd_valid_o, full_o, empty_o, count_o
    );

    modport slave (
        input  wr_en_i, wr_data_i, rd_en_i, flush_i,
        output rd_data_o, rd_valid_o, full_o, empty_o, count_o
    );
`endif
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Pointer/flag controller that turns a dual-port RAM (port 1 write, port 2 read) into a
// single-clock FIFO. Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags.
module sync_fifo_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    sync_fifo_ctrl_if.slave       fifo,
    output logic                  ram_cs_o,
    output logic                  ram_wren1_o,
    output logic [ADDR_WIDTH-1:0] ram_addr1_o,
    output logic [DATA_WIDTH-1:0] ram_wr_data1_o,
    output logic                  ram_wren2_o,
    output logic [ADDR_WIDTH-1:0] ram_addr2_o,
    input  logic [DATA_WIDTH-1:0] ram_rd_data2_i
);
    localparam int PTR_W = ADDR_WIDTH + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             rd_valid_q, rd_valid_d;

    logic             full;
    logic             empty;
    logic [PTR_W-1:0] count;
    logic             wr_acc;
    logic             rd_acc;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0])
              && (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
        count = wr_ptr_q - rd_ptr_q;
    end

    // A flush or reset in the same cycle swallows both requests.
    always_comb begin
        wr_acc = fifo.wr_en_i & ~full  & ~fifo.flush_i & ~rst;
        rd_acc = fifo.rd_en_i & ~empty & ~fifo.flush_i & ~rst;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = 1'b0;
        if (fifo.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            rd_valid_d = rd_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (fifo.wr_en_i & full);
        underflow_d = underflow_q | (fifo.rd_en_i & empty);
        if (fifo.flush_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign fifo.overflow_o  = overflow_q;
    assign fifo.underflow_o = underflow_q;
`endif

    // The RAM registers mem[rd_ptr] every cycle, so data lines up with rd_valid one cycle later.
    assign ram_cs_o        = ~rst;
    assign ram_wren1_o     = wr_acc;
    assign ram_addr1_o     = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_wr_data1_o  = fifo.wr_data_i;
    assign ram_wren2_o     = 1'b0;
    assign ram_addr2_o     = rd_ptr_q[ADDR_WIDTH-1:0];

    assign fifo.rd_data_o  = ram_rd_data2_i;
    assign fifo.rd_valid_o = rd_valid_q;
    assign fifo.full_o     = full;
    assign fifo.empty_o    = empty;
    assign fifo.count_o    = count;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: directed vector table, then queue-model sequences for the
// long fill/drain, wrap, full/empty corner and flush/reset cases.
module tb_sync_fifo_ctrl;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sync_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fif ();

    logic          ram_cs;
    logic          ram_wren1;
    logic [AW-1:0] ram_addr1;
    logic [DW-1:0] ram_wr_data1;
    logic          ram_wren2;
    logic [AW-1:0] ram_addr2;
    logic [DW-1:0] ram_rd_data2;

    sync_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo           (fif),
        .ram_cs_o       (ram_cs),
        .ram_wren1_o    (ram_wren1),
        .ram_addr1_o    (ram_addr1),
        .ram_wr_data1_o (ram_wr_data1),
        .ram_wren2_o    (ram_wren2),
        .ram_addr2_o    (ram_addr2),
        .ram_rd_data2_i (ram_rd_data2)
    );

    // Behavioural dual-port RAM with a registered read on port 2.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_wren1) mem[ram_addr1] <= ram_wr_data1;
            ram_rd_data2 <= mem[ram_addr2];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic          rs;
        logic          fl;
        logic          wr;
        logic          rd;
        logic [DW-1:0] data;
        logic          e_wren;
        logic [AW:0]   e_count;
        logic          e_empty;
        logic          e_full;
        logic          e_valid;
        logic [DW-1:0] e_data;
    } vec_t;

    function automatic vec_t v(input logic rs, input logic fl, input logic wr, input logic rd,
                               input logic [DW-1:0] d, input logic ew, input int ec,
                               input logic ee, input logic ef, input logic ev,
                               input logic [DW-1:0] ed);
        vec_t t;
        t.rs = rs; t.fl = fl; t.wr = wr; t.rd = rd; t.data = d;
        t.e_wren = ew; t.e_count = (AW+1)'(ec); t.e_empty = ee; t.e_full = ef;
        t.e_valid = ev; t.e_data = ed;
        return t;
    endfunction

    // Reference model: a queue of expected words plus sticky error flags.
    logic [DW-1:0] m_q[$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;

    task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit f, input bit rs);
        bit            wacc, racc, full_m, empty_m;
        logic [DW-1:0] exp_data;
        fif.wr_en_i   = w;
        fif.wr_data_i = d;
        fif.rd_en_i   = r;
        fif.flush_i   = f;
        rst           = rs;
        full_m  = (m_q.size() == DEPTH);
        empty_m = (m_q.size() == 0);
        wacc = w && !rs && !f && !full_m;
        racc = r && !rs && !f && !empty_m;
        #1;
        chk("wren1", 32'(ram_wren1), 32'(wacc));
        chk("cs", 32'(ram_cs), 32'(!rs));
        exp_data = '0;
        if (rs || f) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_ovf = m_ovf || (w && full_m);
            m_udf = m_udf || (r && empty_m);
            if (racc) exp_data = m_q.pop_front();
            if (wacc) m_q.push_back(d);
        end
        @(posedge clk);
        #1;
        chk("rd_valid", 32'(fif.rd_valid_o), 32'(racc));
        if (racc) chk("rd_data", 32'(fif.rd_data_o), 32'(exp_data));
        chk("count", 32'(fif.count_o), 32'(m_q.size()));
        chk("empty", 32'(fif.empty_o), 32'(m_q.size() == 0));
        chk("full", 32'(fif.full_o), 32'(m_q.size() == DEPTH));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("overflow", 32'(fif.overflow_o), 32'(m_ovf));
        chk("underflow", 32'(fif.underflow_o), 32'(m_udf));
`endif
    endtask

    vec_t tbl[17];

    initial begin
        rst = 1'b1;
        fif.wr_en_i = 1'b0; fif.wr_data_i = '0; fif.rd_en_i = 1'b0; fif.flush_i = 1'b0;

        //          rs fl wr rd data   wren cnt emp full val data
        tbl[0]  = v(1, 0, 1, 1, 8'h11, 0,   0,  1,  0,   0,  8'h00);
        tbl[1]  = v(1, 0, 1, 1, 8'h11, 0,   0,  1,  0,   0,  8'h00);
        tbl[2]  = v(0, 0, 1, 0, 8'h11, 1,   1,  0,  0,   0,  8'h00);
        tbl[3]  = v(0, 0, 1, 0, 8'h22, 1,   2,  0,  0,   0,  8'h00);
        tbl[4]  = v(0, 0, 0, 1, 8'h00, 0,   1,  0,  0,   1,  8'h11);
        tbl[5]  = v(0, 0, 1, 1, 8'h33, 1,   1,  0,  0,   1,  8'h22);
        tbl[6]  = v(0, 0, 0, 1, 8'h00, 0,   0,  1,  0,   1,  8'h33);
        tbl[7]  = v(0, 0, 0, 1, 8'h00, 0,   0,  1,  0,   0,  8'h00);
        tbl[8]  = v(0, 0, 1, 1, 8'h44, 1,   1,  0,  0,   0,  8'h00);
        tbl[9]  = v(0, 0, 1, 0, 8'h55, 1,   2,  0,  0,   0,  8'h00);
        tbl[10] = v(0, 1, 1, 1, 8'h66, 0,   0,  1,  0,   0,  8'h00);
        tbl[11] = v(0, 0, 0, 1, 8'h00, 0,   0,  1,  0,   0,  8'h00);
        tbl[12] = v(0, 0, 1, 0, 8'h66, 1,   1,  0,  0,   0,  8'h00);
        tbl[13] = v(0, 0, 0, 1, 8'h00, 0,   0,  1,  0,   1,  8'h66);
        tbl[14] = v(0, 0, 1, 0, 8'h77, 1,   1,  0,  0,   0,  8'h00);
        tbl[15] = v(1, 0, 0, 1, 8'h00, 0,   0,  1,  0,   0,  8'h00);
        tbl[16] = v(0, 0, 0, 0, 8'h00, 0,   0,  1,  0,   0,  8'h00);

        for (int i = 0; i < 17; i++) begin
            rst           = tbl[i].rs;
            fif.flush_i   = tbl[i].fl;
            fif.wr_en_i   = tbl[i].wr;
            fif.rd_en_i   = tbl[i].rd;
            fif.wr_data_i = tbl[i].data;
            #1;
            chk("tbl_wren1", 32'(ram_wren1), 32'(tbl[i].e_wren));
            chk("tbl_cs", 32'(ram_cs), 32'(!tbl[i].rs));
            chk("tbl_wren2", 32'(ram_wren2), 32'(0));
            @(posedge clk);
            #1;
            chk("tbl_count", 32'(fif.count_o), 32'(tbl[i].e_count));
            chk("tbl_empty", 32'(fif.empty_o), 32'(tbl[i].e_empty));
            chk("tbl_full", 32'(fif.full_o), 32'(tbl[i].e_full));
            chk("tbl_valid", 32'(fif.rd_valid_o), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) chk("tbl_data", 32'(fif.rd_data_o), 32'(tbl[i].e_data));
            $display("vec %0d: rst=%0b flush=%0b wr=%0b rd=%0b data=%02h -> count=%0d empty=%0b full=%0b valid=%0b rdata=%02h",
                     i, tbl[i].rs, tbl[i].fl, tbl[i].wr, tbl[i].rd, tbl[i].data,
                     fif.count_o, fif.empty_o, fif.full_o, fif.rd_valid_o, fif.rd_data_o);
        end

        // 256 words in, 256 out, in order
        for (int i = 0; i < 256; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("seq256_empty", 32'(fif.empty_o), 32'(1));
        $display("seq: 256-word write/read done");

        // Fill to full, drop an extra 0xAA write, then drain
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i % 170), 1'b0, 1'b0, 1'b0);
        chk("fill_count", 32'(fif.count_o), 32'(DEPTH));
        cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        chk("overwrite_full", 32'(fif.full_o), 32'(1));
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            if (fif.rd_valid_o) chk("no_aa", 32'(fif.rd_data_o == 8'hAA), 32'(0));
        end
        $display("seq: full/overflow/drain done");

        // Full plus both requests: read wins, full drops
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i ^ 8'h5C), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        chk("full_both_count", 32'(fif.count_o), 32'(DEPTH - 1));
        chk("full_both_full", 32'(fif.full_o), 32'(0));
        while (m_q.size() > 5) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        $display("seq: full plus both requests done");

        // Streaming at count 5 long enough for both pointers to wrap
        for (int i = 0; i < 3000; i++) cycle(1'b1, 8'(i * 7), 1'b1, 1'b0, 1'b0);
        chk("stream_count", 32'(fif.count_o), 32'(5));
        while (m_q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        $display("seq: 3000-cycle streaming done");

        // Empty plus both requests: write wins, no read data
        cycle(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        chk("empty_both_count", 32'(fif.count_o), 32'(1));
        chk("empty_both_valid", 32'(fif.rd_valid_o), 32'(0));
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        $display("seq: empty plus both requests done");

        // Flush and reset with a pending read
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i + 8'h90), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("flush_count", 32'(fif.count_o), 32'(0));
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i + 8'hC0), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("rst_count", 32'(fif.count_o), 32'(0));
        cycle(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        $display("seq: flush/reset with pending read done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
